// File: rtl/fifo_rd_check.sv
// Read-side controller for the FIFO loopback test. It waits for full, drains the FIFO in one burst
// and checks the returned words against the writer's wrapping incrementing sequence.
module fifo_rd_check #(
    parameter int DATA_W   = 8,
    parameter int WRAP_VAL = 254,
    parameter int RD_LAT   = 1,
    parameter int CNT_W    = 16
) (
    input  logic              rd_clk,
    input  logic              sys_rst_n,
    input  logic              rd_rst_busy,
    input  logic              full,
    input  logic              almost_empty,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [DATA_W-1:0] WRAP_W = DATA_W'(WRAP_VAL);

    logic [1:0]        r_state;
    logic              r_full_d0;
    logic              r_full_d1;
    logic              r_rd_en;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_seeded;
    logic [DATA_W-1:0] r_exp;
    logic              r_err_flag;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_burst_cnt;

    logic              w_data_vld;
    logic              w_pipe_empty;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_next_exp;

    // A word still in the pipe when the FIFO enters reset is dropped, never checked.
    assign w_data_vld   = r_vld_pipe[RD_LAT-1] & ~rd_rst_busy;
    assign w_pipe_empty = (r_vld_pipe == '0);
    assign w_next_exp   = (fifo_rd_data == WRAP_W) ? '0 : fifo_rd_data + 1'b1;
    assign w_mismatch   = r_seeded && (fifo_rd_data != r_exp);

    always_ff @(posedge rd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_full_d0 <= 1'b0;
            r_full_d1 <= 1'b0;
        end else begin
            r_full_d0 <= full & ~rd_rst_busy;
            r_full_d1 <= r_full_d0 & ~rd_rst_busy;
        end
    end

    always_ff @(posedge rd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_en     <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (r_full_d1 && !rd_rst_busy) begin
                        r_state <= ST_READ;
                        r_rd_en <= ~empty;
                    end
                end
                ST_READ: begin
                    if (rd_rst_busy) begin
                        r_state <= ST_IDLE;
                        r_rd_en <= 1'b0;
                    end else if (almost_empty || empty) begin
                        // The read issued last cycle collects the final word.
                        r_state <= ST_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_en <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_rd_en <= 1'b0;
                    if (rd_rst_busy) begin
                        r_state <= ST_IDLE;
                    end else if (w_pipe_empty) begin
                        r_state     <= ST_IDLE;
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_vld_pipe
            always_ff @(posedge rd_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_vld_pipe[gi] <= 1'b0;
                end else if (rd_rst_busy) begin
                    r_vld_pipe[gi] <= 1'b0;
                end else if (gi == 0) begin
                    r_vld_pipe[gi] <= r_rd_en;
                end else begin
                    r_vld_pipe[gi] <= r_vld_pipe[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    // Checker state survives across bursts; only reset re-seeds it.
    always_ff @(posedge rd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_vld   <= 1'b0;
            r_rd_data  <= '0;
            r_seeded   <= 1'b0;
            r_exp      <= '0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_rd_vld <= w_data_vld;
            if (w_data_vld) begin
                r_rd_data <= fifo_rd_data;
                r_seeded  <= 1'b1;
                r_exp     <= w_next_exp;
                if (w_mismatch) begin
                    r_err_flag <= 1'b1;
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign fifo_rd_en  = r_rd_en;
    assign rd_vld      = r_rd_vld;
    assign rd_data_out = r_rd_data;
    assign err_flag    = r_err_flag;
    assign err_cnt     = r_err_cnt;
    assign burst_cnt   = r_burst_cnt;
    assign busy        = (r_state != ST_IDLE);

endmodule
